// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-op encodings and the parity unit's FSM states.
package alu_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } lpu_state_t;

endpackage

// File: rtl/logic_parity_unit_popcount_chunk.sv
// Combinational ones counter for one CHUNK-bit slice of the logic result.
module popcount_chunk #(
  parameter int CHUNK = 1,
  parameter int CNT_W = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] i_slice,
  output logic [CNT_W-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      o_count = o_count + CNT_W'(i_slice[i]);
    end
  end

endmodule

// File: rtl/logic_parity_unit.sv
// Multi-cycle bitwise logic unit: applies AND/OR/XOR/XNOR, extends the result,
// then scans it CHUNK bits per cycle for a ones count and even-parity flag.
module logic_parity_unit
  import alu_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int OUT_WIDTH = 32,
  parameter int CHUNK     = 1,
  parameter int SIGN_EXT  = 1,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     number1,
  input  logic [WIDTH-1:0]     number2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] output_result,
  output logic [CNT_W-1:0]     ones_count,
  output logic                 balance
);

  localparam int IDX_W = $clog2(WIDTH + CHUNK + 1);
  localparam int PC_W  = $clog2(CHUNK + 1);

  if (OUT_WIDTH < WIDTH || CHUNK < 1 || CHUNK > WIDTH) begin : g_param_check
    $error("logic_parity_unit: need OUT_WIDTH >= WIDTH and 1 <= CHUNK <= WIDTH");
  end

  lpu_state_t             r_state;
  logic [WIDTH-1:0]       r_calc;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [OUT_WIDTH-1:0]   r_result;
  logic [CNT_W-1:0]       r_ones;
  logic                   r_balance;
  logic                   r_out_valid;

  logic [WIDTH-1:0]       w_calc;
  logic [WIDTH+CHUNK-1:0] w_padded;
  logic [CHUNK-1:0]       w_slice;
  logic [PC_W-1:0]        w_chunk_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_last;
  logic [OUT_WIDTH-1:0]   w_ext;

  always_comb begin
    case (op)
      OP_AND:  w_calc = number1 & number2;
      OP_OR:   w_calc = number1 | number2;
      OP_XOR:  w_calc = number1 ^ number2;
      default: w_calc = ~(number1 ^ number2);
    endcase
  end

  // Zero padding above the result masks the tail of a partial last chunk.
  assign w_padded   = {{CHUNK{1'b0}}, r_calc};
  assign w_slice    = CHUNK'(w_padded >> r_idx);
  assign w_cnt_next = r_cnt + CNT_W'(w_chunk_cnt);
  assign w_last     = (int'(r_idx) + CHUNK >= WIDTH);

  popcount_chunk #(
    .CHUNK (CHUNK),
    .CNT_W (PC_W)
  ) u_popcount (
    .i_slice (w_slice),
    .o_count (w_chunk_cnt)
  );

  if (OUT_WIDTH == WIDTH) begin : g_no_ext
    assign w_ext = r_calc;
  end else begin : g_ext
    logic w_fill;
    assign w_fill = (SIGN_EXT != 0) ? r_calc[WIDTH-1] : 1'b0;
    assign w_ext  = {{(OUT_WIDTH-WIDTH){w_fill}}, r_calc};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_calc      <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_result    <= '0;
      r_ones      <= '0;
      r_balance   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_calc  <= w_calc;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          r_cnt <= w_cnt_next;
          r_idx <= r_idx + IDX_W'(CHUNK);
          if (w_last) begin
            r_result    <= w_ext;
            r_ones      <= w_cnt_next;
            r_balance   <= ~w_cnt_next[0];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready      = (r_state == IDLE);
  assign out_valid     = r_out_valid;
  assign output_result = r_result;
  assign ones_count    = r_ones;
  assign balance       = r_balance;

endmodule
